// File: rtl/fsk_link_pkg.sv
// =============================================================================
// fsk_link_pkg : constants and helpers shared by both ends of the FSK light link
// Revision     : 1.0
// =============================================================================
`default_nettype none

package fsk_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TX_BIT = 2'd1,
    ST_DONE   = 2'd2
  } tx_state_e;

  // Defaults shared with the analyzer configuration so both ends agree
  localparam int DEFAULT_FREQUENCY0  = 5000;
  localparam int DEFAULT_FREQUENCY1  = 10000;
  localparam int DEFAULT_BIT_PERIODS = 16;

  function automatic int half_period(input int clock_hz, input int freq_hz);
    if (freq_hz <= 0) return 0;
    return clock_hz / (2 * freq_hz);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsk_light_transmitter_swg.sv
// =============================================================================
// square_wave_generator : reloadable half-period square wave with toggle strobe
// Revision              : 1.0
// =============================================================================
`default_nettype none

module square_wave_generator #(
  parameter int   CNT_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_load,
  output logic             wave,
  output logic             toggle
);

  logic [CNT_W-1:0] half_cnt_q;
  logic             running_q;
  logic             wave_q;

  assign toggle = running_q && (half_cnt_q == CNT_W'(1));
  assign wave   = wave_q;

  // start wins over stop and over the free-running toggle so a new bit
  // always begins high in the same cycle the previous one ends
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_cnt_q <= '0;
      running_q  <= 1'b0;
      wave_q     <= IDLE_LEVEL;
    end else if (start) begin
      half_cnt_q <= half_load;
      running_q  <= 1'b1;
      wave_q     <= 1'b1;
    end else if (stop) begin
      half_cnt_q <= '0;
      running_q  <= 1'b0;
      wave_q     <= IDLE_LEVEL;
    end else if (running_q) begin
      if (toggle) begin
        half_cnt_q <= half_load;
        wave_q     <= ~wave_q;
      end else begin
        half_cnt_q <= half_cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsk_light_transmitter.sv
// =============================================================================
// fsk_light_transmitter : sends a word MSB-first as FSK on/off light on led_out
// Revision              : 1.0
// =============================================================================
`default_nettype none

module fsk_light_transmitter
  import fsk_link_pkg::*;
#(
  parameter int   CLOCK_FREQUENCY = 100000000,
  parameter int   FREQUENCY0      = DEFAULT_FREQUENCY0,
  parameter int   FREQUENCY1      = DEFAULT_FREQUENCY1,
  parameter int   BIT_PERIODS     = DEFAULT_BIT_PERIODS,
  parameter int   DATA_WIDTH      = 8,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          led_out,
  output logic                          busy,
  output logic [$clog2(DATA_WIDTH):0]   bit_index,
  output logic                          done
);

  localparam int HALF0    = half_period(CLOCK_FREQUENCY, FREQUENCY0);
  localparam int HALF1    = half_period(CLOCK_FREQUENCY, FREQUENCY1);
  localparam int HALF_MAX = max_int(HALF0, HALF1);
  localparam int CNT_W    = $clog2(HALF_MAX) + 1;
  localparam int IDX_W    = $clog2(DATA_WIDTH) + 1;
  localparam int TOGGLES  = 2 * BIT_PERIODS;
  localparam int TGL_W    = $clog2(TOGGLES) + 1;

  localparam logic [CNT_W-1:0] HALF0_V = CNT_W'(HALF0);
  localparam logic [CNT_W-1:0] HALF1_V = CNT_W'(HALF1);

  if (HALF0 < 1 || HALF1 < 1 || HALF0 == HALF1 || BIT_PERIODS < 1 || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("fsk_light_transmitter: half periods must be >=1 and distinct");
  end

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      bit_index_q;
  logic [TGL_W-1:0]      toggle_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  data_ready_q;

  logic                  w_toggle;
  logic                  w_wave;
  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_stop;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0]      w_half_load;

  assign w_accept     = (state_q == ST_IDLE) && enable && data_ready_q && data_valid;
  assign w_abort      = (state_q == ST_TX_BIT) && !enable;
  assign w_bit_end    = (state_q == ST_TX_BIT) && enable && w_toggle &&
                        (toggle_cnt_q == TGL_W'(TOGGLES - 1));
  assign w_last_bit   = (bit_index_q == '0);
  assign w_shift_next = shift_q << 1;
  assign w_start      = w_accept || (w_bit_end && !w_last_bit);
  assign w_stop       = w_abort  || (w_bit_end && w_last_bit);

  // Half period follows the bit about to be (or being) transmitted
  always_comb begin
    w_half_load = shift_q[DATA_WIDTH-1] ? HALF1_V : HALF0_V;
    if (state_q == ST_IDLE) begin
      w_half_load = data[DATA_WIDTH-1] ? HALF1_V : HALF0_V;
    end else if (w_bit_end) begin
      w_half_load = w_shift_next[DATA_WIDTH-1] ? HALF1_V : HALF0_V;
    end
  end

  square_wave_generator #(
    .CNT_W      (CNT_W),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_swg (
    .clock     (clock),
    .reset     (reset),
    .start     (w_start),
    .stop      (w_stop),
    .half_load (w_half_load),
    .wave      (w_wave),
    .toggle    (w_toggle)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_index_q  <= '0;
      toggle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          data_ready_q <= enable;
          if (w_accept) begin
            shift_q      <= data;
            bit_index_q  <= IDX_W'(DATA_WIDTH - 1);
            toggle_cnt_q <= '0;
            busy_q       <= 1'b1;
            data_ready_q <= 1'b0;
            state_q      <= ST_TX_BIT;
          end
        end
        ST_TX_BIT: begin
          if (!enable) begin
            toggle_cnt_q <= '0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (w_toggle) begin
            if (w_bit_end) begin
              toggle_cnt_q <= '0;
              if (w_last_bit) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                shift_q     <= w_shift_next;
                bit_index_q <= bit_index_q - IDX_W'(1);
              end
            end else begin
              toggle_cnt_q <= toggle_cnt_q + TGL_W'(1);
            end
          end
        end
        ST_DONE: begin
          data_ready_q <= enable;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Gating with enable keeps data_ready from advertising a slot enable forbids
  assign data_ready = data_ready_q && enable;
  assign led_out    = w_wave;
  assign busy       = busy_q;
  assign bit_index  = bit_index_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fsk_light_transmitter.sv
// =============================================================================
// tb_fsk_light_transmitter : directed self-checking bench for the FSK transmitter
// Revision                 : 1.0
// =============================================================================
`default_nettype none

module tb_fsk_light_transmitter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       led_out;
  logic       busy;
  logic [2:0] bit_index;
  logic       done;

  int vectors;
  int miscompares;

  fsk_light_transmitter #(
    .CLOCK_FREQUENCY (1000),
    .FREQUENCY0      (100),
    .FREQUENCY1      (250),
    .BIT_PERIODS     (2),
    .DATA_WIDTH      (4),
    .IDLE_LEVEL      (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .led_out    (led_out),
    .busy       (busy),
    .bit_index  (bit_index),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bit 1 -> half period 2, bit 0 -> half period 5, two full periods per bit
  function automatic int bit_len(input logic b);
    return b ? 8 : 20;
  endfunction

  function automatic int frame_len(input logic [3:0] w);
    int s;
    s = 0;
    for (int b = 0; b < 4; b++) s += bit_len(w[b]);
    return s;
  endfunction

  // Expected led level and bit index in frame cycle n (1-based)
  task automatic expect_at(input logic [3:0] w, input int n, output logic led, output int idx);
    int  pos;
    int  h;
    bit  found;
    pos   = n - 1;
    led   = 1'b0;
    idx   = 0;
    found = 1'b0;
    for (int b = 3; b >= 0; b--) begin
      h = w[b] ? 2 : 5;
      if (!found) begin
        if (pos < 4 * h) begin
          led   = ((pos / h) % 2) == 0;
          idx   = b;
          found = 1'b1;
        end else begin
          pos -= 4 * h;
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (data_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s wait_ready: data_ready=%b required 1 within 20 cycles", name, data_ready);
    end
  endtask

  // Entered at frame cycle 1; leaves the bench sitting in the done cycle
  task automatic check_frame(input logic [3:0] w, input string name);
    logic e_led;
    int   e_idx;
    int   len;
    len = frame_len(w);
    for (int n = 1; n <= len; n++) begin
      expect_at(w, n, e_led, e_idx);
      vectors++;
      if (led_out !== e_led || busy !== 1'b1 || bit_index !== 3'(e_idx) ||
          done !== 1'b0 || data_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s cycle %0d: led=%b busy=%b idx=%0d done=%b rdy=%b required led=%b busy=1 idx=%0d done=0 rdy=0",
                 name, n, led_out, busy, bit_index, done, data_ready, e_led, e_idx);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || led_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_cycle %0d: done=%b busy=%b led=%b required done=1 busy=0 led=0",
               name, len + 1, done, busy, led_out);
    end
  endtask

  task automatic accept_word(input logic [3:0] w, input string name);
    data = w;
    wait_ready(name);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic check_after_done(input string name);
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || led_out !== 1'b0 || data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s post_done: done=%b busy=%b led=%b rdy=%b required 0 0 0 1",
               name, done, busy, led_out, data_ready);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    data       = 4'b0;
    data_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (data_ready !== 1'b0 || led_out !== 1'b0 || busy !== 1'b0 ||
        bit_index !== 3'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b led=%b busy=%b idx=%0d done=%b required all 0",
               data_ready, led_out, busy, bit_index, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_1010();
    enable = 1'b1;
    accept_word(4'b1010, "frame_1010");
    check_frame(4'b1010, "frame_1010");
    check_after_done("frame_1010");
  endtask

  task automatic test_frame_0000();
    accept_word(4'b0000, "frame_0000");
    check_frame(4'b0000, "frame_0000");
    check_after_done("frame_0000");
  endtask

  task automatic test_abort();
    logic e_led;
    int   e_idx;
    accept_word(4'b1111, "abort");
    for (int n = 1; n <= 30; n++) begin
      expect_at(4'b1111, n, e_led, e_idx);
      vectors++;
      if (led_out !== e_led || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_pre cycle %0d: led=%b busy=%b required led=%b busy=1", n, led_out, busy, e_led);
      end
      if (n == 30) enable = 1'b0;
      else tick();
    end
    tick();
    vectors++;
    if (led_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_next: led=%b busy=%b done=%b required 0 0 0", led_out, busy, done);
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || data_ready !== 1'b0 || led_out !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_idle %0d: done=%b rdy=%b led=%b required 0 0 0", n, done, data_ready, led_out);
      end
    end
    enable = 1'b1;
    tick();
    vectors++;
    if (data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reenable: rdy=%b required 1", data_ready);
    end
  endtask

  task automatic test_back_to_back();
    data = 4'b0110;
    wait_ready("b2b");
    data_valid = 1'b1;
    tick();
    data = 4'b1001;
    check_frame(4'b0110, "b2b_first");
    check_after_done("b2b_gap");
    tick();
    data_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || led_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_start: busy=%b led=%b required 1 1", busy, led_out);
    end
    check_frame(4'b1001, "b2b_second");
    check_after_done("b2b_second");
  endtask

  task automatic test_async_reset();
    accept_word(4'b1010, "async_reset");
    for (int n = 1; n < 10; n++) tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (led_out !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: led=%b busy=%b rdy=%b required 0 0 0", led_out, busy, data_ready);
    end
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
    accept_word(4'b1010, "after_reset");
    check_frame(4'b1010, "after_reset");
    check_after_done("after_reset");
  endtask

  task automatic test_idle_disabled();
    enable     = 1'b0;
    data       = 4'b1111;
    data_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      tick();
      vectors++;
      if (data_ready !== 1'b0 || led_out !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_disabled %0d: rdy=%b led=%b busy=%b required 0 0 0", n, data_ready, led_out, busy);
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_frame_1010();
    test_frame_0000();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_idle_disabled();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
